// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller: FSM state
// encoding and default timing constants, so the system controller and any
// bench agree on the numbers.
package clk_gate_pkg;

  localparam logic [1:0] OFF   = 2'b00;
  localparam logic [1:0] WAKE  = 2'b01;
  localparam logic [1:0] ON    = 2'b10;
  localparam logic [1:0] DRAIN = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF   = OFF,
    ST_WAKE  = WAKE,
    ST_ON    = ON,
    ST_DRAIN = DRAIN
  } state_e;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 4;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Requester <-> clock-gate controller handshake. The master is the system
// controller (drives REQ/BUSY); the slave is clk_gate_ctrl.
interface clk_gate_ctrl_if;

  logic       REQ;
  logic       BUSY;
  logic       CLK_EN;
  logic       ACK;
  logic [1:0] STATE;

  modport master (output REQ, output BUSY, input CLK_EN, input ACK, input STATE);
  modport slave  (input REQ, input BUSY, output CLK_EN, output ACK, output STATE);

endinterface

// File: rtl/clk_gate_stats_cnt.sv
// 16-bit saturating count of cycles with the gated clock enabled.
// Synchronous clear has priority over increment.
module clk_gate_stats_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear, else saturating increment while enabled.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller. Produces a registered CLK_EN for a latch
// based clock-gating cell and an ACK once the gated clock is stable; keeps
// the clock running for IDLE_CYCLES after the last use to avoid thrash.
// Optional feature macro: CLK_GATE_STATS_EN adds ON_CYCLES / STATS_CLR.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  clk_gate_ctrl_if.slave    gate
`ifdef CLK_GATE_STATS_EN
  ,
  input  logic              STATS_CLR,
  output logic [15:0]       ON_CYCLES
`endif
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_en_q;
  logic             ack_q;

  // FSM with shared wake/idle down-counter; outputs are registered so
  // CLK_EN only ever changes on a rising CLK edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others, independent of statement order.
      case (state_q)
        ST_OFF: begin
          if (gate.REQ) begin
            state_q  <= ST_WAKE;
            cnt_q    <= WAKE_LOAD;
            clk_en_q <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (!gate.REQ) begin
            state_q <= ST_DRAIN;
            cnt_q   <= IDLE_LOAD;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_ON;
            ack_q   <= 1'b1;
          end
        end
        ST_ON: begin
          if (!gate.REQ && !gate.BUSY) begin
            state_q <= ST_DRAIN;
            cnt_q   <= IDLE_LOAD;
            ack_q   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Clock is still running, so a new request skips the wake phase.
          if (gate.REQ) begin
            state_q <= ST_ON;
            ack_q   <= 1'b1;
          end else if (gate.BUSY) begin
            cnt_q <= IDLE_LOAD;
          end else if (cnt_q == '0) begin
            state_q  <= ST_OFF;
            clk_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_OFF;
          cnt_q    <= '0;
          clk_en_q <= 1'b0;
          ack_q    <= 1'b0;
        end
      endcase
    end
  end

  assign gate.CLK_EN = clk_en_q;
  assign gate.ACK    = ack_q;
  assign gate.STATE  = state_q;

`ifdef CLK_GATE_STATS_EN
  clk_gate_stats_cnt u_stats (
    .clk   (CLK),
    .rst_n (RST),
    .en_i  (clk_en_q),
    .clr_i (STATS_CLR),
    .cnt_o (ON_CYCLES)
  );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (default WAKE=2, IDLE=4). The stimulus
// process pushes expected outputs tagged with the rising-edge number they
// must appear after; a monitor samples on each falling edge and compares.
// Define CLK_GATE_STATS_EN to also exercise the ON_CYCLES counter.
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  typedef struct {
    int         cyc;
    logic       clk_en;
    logic       ack;
    logic [1:0] state;
    int         on_cyc;   // -1: not checked
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur;

  clk_gate_ctrl_if gif ();

`ifdef CLK_GATE_STATS_EN
  logic        stats_clr;
  logic [15:0] on_cycles;
`endif

  clk_gate_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .gate      (gif)
`ifdef CLK_GATE_STATS_EN
    ,
    .STATS_CLR (stats_clr),
    .ON_CYCLES (on_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  // Rising-edge counter; read only on falling edges.
  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input int at, input int act, input int req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_errors = n_errors + 1;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, at, act, req);
    end
  endtask

  task automatic expect_at(input int c, input logic e, input logic a,
                           input logic [1:0] s, input int on = -1);
    exp_t x;
    x.cyc = c; x.clk_en = e; x.ack = a; x.state = s; x.on_cyc = on;
    sb.push_back(x);
  endtask

  // Return at the falling edge that follows rising edge n.
  task automatic at_neg(input int n);
    forever begin
      @(negedge CLK);
      if (cyc >= n) break;
    end
  endtask

  // Monitor: invariant every cycle, scoreboard entries on their edge.
  always @(negedge CLK) begin
    if (RST === 1'b1) check("ack_implies_clk_en", cyc, int'(!gif.ACK || gif.CLK_EN), 1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc < cyc) begin
        check("missed_entry", cur.cyc, cyc, cur.cyc);
      end else begin
        check("clk_en", cyc, int'(gif.CLK_EN), int'(cur.clk_en));
        check("ack",    cyc, int'(gif.ACK),    int'(cur.ack));
        check("state",  cyc, int'(gif.STATE),  int'(cur.state));
`ifdef CLK_GATE_STATS_EN
        if (cur.on_cyc >= 0) check("on_cycles", cyc, int'(on_cycles), cur.on_cyc);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0;
    gif.REQ = 1'b0;
    gif.BUSY = 1'b0;
`ifdef CLK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    // Reset state, held and after release.
    expect_at(1, 0, 0, OFF, 0);
    expect_at(3, 0, 0, OFF, 0);
    at_neg(2);
    RST = 1'b1;

    // Asynchronous reset mid-WAKE, then idle after release.
    at_neg(4);
    expect_at(5, 1, 0, WAKE);
    expect_at(6, 0, 0, OFF, 0);
    expect_at(8, 0, 0, OFF);
    expect_at(9, 0, 0, OFF);
    gif.REQ = 1'b1;
    at_neg(5);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    gif.REQ = 1'b0;
    at_neg(7);
    RST = 1'b1;

    // Wake latency (REQ sampled at edge 10) and idle gating (drop at 20).
    at_neg(9);
    expect_at(10, 1, 0, WAKE);
    expect_at(11, 1, 0, WAKE);
    expect_at(12, 1, 1, ON);
    expect_at(19, 1, 1, ON);
    expect_at(20, 1, 0, DRAIN);
    expect_at(23, 1, 0, DRAIN);
    expect_at(24, 0, 0, OFF);
    expect_at(25, 0, 0, OFF, 14);
    gif.REQ = 1'b1;
    at_neg(19);
    gif.REQ = 1'b0;

    // BUSY holds ON, then BUSY in DRAIN reloads the idle counter.
    at_neg(29);
    expect_at(30, 1, 0, WAKE);
    expect_at(32, 1, 1, ON);
    expect_at(36, 1, 1, ON);
    expect_at(37, 1, 1, ON);
    expect_at(40, 1, 0, DRAIN);
    expect_at(44, 1, 0, DRAIN);
    expect_at(47, 1, 0, DRAIN);
    expect_at(48, 0, 0, OFF);
    gif.REQ = 1'b1;
    at_neg(35);
    gif.REQ = 1'b0; gif.BUSY = 1'b1;
    at_neg(37);
    gif.REQ = 1'b1; gif.BUSY = 1'b0;
    at_neg(39);
    gif.REQ = 1'b0;
    at_neg(42);
    gif.BUSY = 1'b1;
    at_neg(44);
    gif.BUSY = 1'b0;

    // Re-request during DRAIN, and REQ beating BUSY in DRAIN.
    at_neg(49);
    expect_at(50, 1, 0, WAKE);
    expect_at(52, 1, 1, ON);
    expect_at(60, 1, 0, DRAIN);
    expect_at(62, 1, 0, DRAIN);
    expect_at(63, 1, 1, ON);
    expect_at(64, 1, 1, ON);
    expect_at(70, 1, 0, DRAIN);
    expect_at(71, 1, 1, ON);
    expect_at(73, 1, 0, DRAIN);
    expect_at(76, 1, 0, DRAIN);
    expect_at(77, 0, 0, OFF);
    gif.REQ = 1'b1;
    at_neg(59);
    gif.REQ = 1'b0;
    at_neg(62);
    gif.REQ = 1'b1;
    at_neg(69);
    gif.REQ = 1'b0;
    at_neg(70);
    gif.REQ = 1'b1; gif.BUSY = 1'b1;
    at_neg(72);
    gif.REQ = 1'b0; gif.BUSY = 1'b0;

    // REQ withdrawn during WAKE: straight to DRAIN, ACK never rises.
    at_neg(79);
    expect_at(80, 1, 0, WAKE);
    expect_at(81, 1, 0, DRAIN);
    expect_at(84, 1, 0, DRAIN);
    expect_at(85, 0, 0, OFF);
`ifdef CLK_GATE_STATS_EN
    // Enabled cycles so far: 14 + 18 + 27 + 5.
    expect_at(86, 0, 0, OFF, 64);
    expect_at(87, 0, 0, OFF, 0);
    expect_at(88, 1, 0, WAKE, 0);
    expect_at(89, 1, 0, WAKE, 1);
    expect_at(90, 1, 1, ON, 2);
    expect_at(65622, 1, 1, ON, 65534);
    expect_at(65623, 1, 1, ON, 65535);
    expect_at(65700, 1, 1, ON, 65535);
    expect_at(65701, 1, 0, DRAIN, 65535);
    expect_at(65702, 1, 0, DRAIN, 0);
    expect_at(65703, 1, 0, DRAIN, 1);
`endif
    gif.REQ = 1'b1;
    at_neg(80);
    gif.REQ = 1'b0;

`ifdef CLK_GATE_STATS_EN
    at_neg(86);
    stats_clr = 1'b1;
    at_neg(87);
    stats_clr = 1'b0;
    gif.REQ = 1'b1;
    at_neg(65700);
    gif.REQ = 1'b0;
    at_neg(65701);
    stats_clr = 1'b1;
    at_neg(65702);
    stats_clr = 1'b0;
    at_neg(65705);
`else
    at_neg(90);
`endif

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      check("unchecked_entry", cur.cyc, cyc, cur.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
